// File: rtl/board_pkg.sv
// Shared Battleship board constants, cell encoding and clear-engine states.
// Used by board_clear_engine (optional BOARD_CLEAR_VERIFY_EN read-back).
package board_pkg;

  localparam int BOARD_ROWS  = 10;
  localparam int BOARD_COLS  = 10;
  localparam int BOARD_CELLS = BOARD_ROWS * BOARD_COLS;
  localparam int BOARD_AW    = $clog2(BOARD_CELLS);

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    BCE_IDLE,
    BCE_CLEAR,
    BCE_VERIFY,
    BCE_VTAIL,
    BCE_FIN
  } bce_state_t;

endpackage

// File: rtl/board_clear_engine_rise_detect.sv
// Registers the start level and emits a one-cycle pulse on its rising edge.
// Holding the level high yields exactly one pulse.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b0;
    else          level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/board_clear_engine.sv
// Clears the board RAM to FILL on a start edge, then raises sticky done.
// Define BOARD_CLEAR_VERIFY_EN to add a read-back pass that drives err.
module board_clear_engine
  import board_pkg::*;
#(
  parameter int ROWS   = BOARD_ROWS,
  parameter int COLS   = BOARD_COLS,
  parameter int CELL_W = 2,
  parameter logic [CELL_W-1:0] FILL = '0,
  localparam int N  = ROWS * COLS,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [AW-1:0]     mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  bce_state_t    state, nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          done_q, done_nxt;
  logic          req;

  rise_detect u_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (start),
    .pulse   (req)
  );

`ifdef BOARD_CLEAR_VERIFY_EN
  logic chk_q;
  logic err_q, err_nxt;

  // Read issued in VERIFY returns next cycle; compare it then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chk_q <= (state == BCE_VERIFY);
      err_q <= err_nxt;
    end
  end

  always_comb begin
    err_nxt = err_q;
    if (state == BCE_IDLE && req)
      err_nxt = 1'b0;
    else if (chk_q && mem_rdata != FILL)
      err_nxt = 1'b1;
  end

  assign err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BCE_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    done_nxt = done_q;
    unique case (state)
      BCE_IDLE: begin
        if (req) begin
          done_nxt = 1'b0;
          cnt_nxt  = '0;
          nxt      = BCE_CLEAR;
        end
      end
      BCE_CLEAR: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
`ifdef BOARD_CLEAR_VERIFY_EN
          nxt = BCE_VERIFY;
`else
          nxt      = BCE_FIN;
          done_nxt = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
`ifdef BOARD_CLEAR_VERIFY_EN
      BCE_VERIFY: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          nxt     = BCE_VTAIL;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      BCE_VTAIL: begin
        nxt      = BCE_FIN;
        done_nxt = 1'b1;
      end
`endif
      BCE_FIN: nxt = BCE_IDLE;
      default: nxt = BCE_IDLE;
    endcase
  end

  assign mem_we    = (state == BCE_CLEAR);
  assign mem_wdata = FILL;
  assign mem_addr  = (state == BCE_CLEAR || state == BCE_VERIFY)
                   ? cnt : '0;
  assign busy      = (state == BCE_CLEAR)
                   || (state == BCE_VERIFY)
                   || (state == BCE_VTAIL);
  assign done      = done_q;

endmodule

// File: tb/tb_board_clear_engine.sv
// Directed bench for board_clear_engine: default 10x10 board plus a
// 4x3 FILL=3 instance, with RAM models behind both.
module tb_board_clear_engine;

`ifdef BOARD_CLEAR_VERIFY_EN
  localparam int LAT  = 202;
  localparam int LAT2 = 26;
`else
  localparam int LAT  = 101;
  localparam int LAT2 = 13;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [6:0] mem_addr;
  logic [1:0] mem_wdata;
  logic       mem_we;
  logic [1:0] mem_rdata;
  logic       busy, done, err;

  logic       start2;
  logic [3:0] addr2;
  logic [1:0] wdata2;
  logic       we2;
  logic [1:0] rdata2;
  logic       busy2, done2, err2;

  logic       junk;
  logic       stuck;
  logic [1:0] ram  [0:99];
  logic [1:0] ram2 [0:11];

  int n_cmp = 0;
  int n_bad = 0;

  int t_we   [0:699];
  int t_addr [0:699];
  int t_busy [0:699];
  int t_done [0:699];
  int t_err  [0:699];
  int t_wd   [0:699];

  typedef struct {
    int cyc;
    int we;
    int addr;
    int busy;
    int done;
  } vec_t;

  vec_t tbl [0:9];

  always #5 clk = ~clk;

  board_clear_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  board_clear_engine #(
    .ROWS   (4),
    .COLS   (3),
    .CELL_W (2),
    .FILL   (2'b11)
  ) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start2),
    .mem_addr  (addr2),
    .mem_wdata (wdata2),
    .mem_we    (we2),
    .mem_rdata (rdata2),
    .busy      (busy2),
    .done      (done2),
    .err       (err2)
  );

  always @(posedge clk) begin
    if (junk) begin
      for (int i = 0; i < 100; i++) ram[i] <= 2'b10;
      for (int i = 0; i < 12; i++) ram2[i] <= 2'b01;
    end else begin
      if (mem_we && mem_addr < 7'd100) ram[mem_addr] <= mem_wdata;
      if (we2 && addr2 < 4'd12) ram2[addr2] <= wdata2;
    end
    if (stuck && mem_addr == 7'd33) mem_rdata <= 2'b01;
    else if (mem_addr < 7'd100)     mem_rdata <= ram[mem_addr];
    else                            mem_rdata <= 2'b00;
    rdata2 <= (addr2 < 4'd12) ? ram2[addr2] : 2'b00;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic quiet();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_seq(input int ncyc, input int lo_at, input int hi_at);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1 start = (i < lo_at) || (i >= hi_at);
      @(negedge clk);
      t_we[i]   = int'(mem_we);
      t_addr[i] = int'(mem_addr);
      t_busy[i] = int'(busy);
      t_done[i] = int'(done);
      t_err[i]  = int'(err);
      t_wd[i]   = int'(mem_wdata);
    end
  endtask

  task automatic count_writes(input int ncyc, output int nw,
                              output int order_bad, output int wd_bad);
    nw = 0;
    order_bad = 0;
    wd_bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (t_we[i] != 0) begin
        if (t_addr[i] != nw) order_bad++;
        if (t_wd[i] != 0) wd_bad++;
        nw++;
      end
    end
  endtask

  initial begin
    int nw, ob, wb, nz, hit, nw2, ob2, wb2;

    tbl[0] = '{0,   0, 0,  0, 0};
    tbl[1] = '{1,   1, 0,  1, 0};
    tbl[2] = '{2,   1, 1,  1, 0};
    tbl[3] = '{41,  1, 40, 1, 0};
    tbl[4] = '{100, 1, 99, 1, 0};
    tbl[5] = '{LAT, 0, 0,  0, 1};
    tbl[6] = '{LAT + 3, 0, 0, 0, 1};
`ifdef BOARD_CLEAR_VERIFY_EN
    tbl[7] = '{101, 0, 0,  1, 0};
    tbl[8] = '{200, 0, 99, 1, 0};
    tbl[9] = '{201, 0, 0,  1, 0};
`else
    tbl[7] = '{10,  1, 9,  1, 0};
    tbl[8] = '{60,  1, 59, 1, 0};
    tbl[9] = '{99,  1, 98, 1, 0};
`endif

    reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    stuck   = 1'b0;
    junk    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({done, err, busy, mem_we, mem_addr}), 0);
    chk("reset_outputs2", int'({done2, err2, busy2, we2, addr2}), 0);
    junk    = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // First clear, start then held high for the rest of 600 cycles.
    run_seq(600, 600, 600);
    for (int v = 0; v < 10; v++) begin
      chk($sformatf("tbl%0d_we", v),   t_we[tbl[v].cyc],   tbl[v].we);
      chk($sformatf("tbl%0d_addr", v), t_addr[tbl[v].cyc], tbl[v].addr);
      chk($sformatf("tbl%0d_busy", v), t_busy[tbl[v].cyc], tbl[v].busy);
      chk($sformatf("tbl%0d_done", v), t_done[tbl[v].cyc], tbl[v].done);
    end
    count_writes(600, nw, ob, wb);
    chk("held_write_count", nw, 100);
    chk("write_order", ob, 0);
    chk("write_data", wb, 0);
    chk("clean_err", t_err[LAT], 0);
    chk("held_done_end", t_done[599], 1);
    nz = 0;
    for (int i = 0; i < 100; i++) if (ram[i] != 2'b00) nz++;
    chk("ram_cleared", nz, 0);

    // Re-request after done; second edge mid-clear must be ignored.
    quiet();
    run_seq(LAT + 10, 20, 41);
    count_writes(LAT + 10, nw, ob, wb);
    chk("reissue_done_before", t_done[0], 1);
    chk("reissue_done_drop", t_done[1], 0);
    chk("midclear_addr40", t_addr[41], 40);
    chk("midclear_write_count", nw, 100);
    chk("midclear_order", ob, 0);
    chk("midclear_done", t_done[LAT], 1);
    chk("midclear_not_early", t_done[LAT - 1], 0);

    // Reset while writing address 57.
    quiet();
    hit = 0;
    for (int i = 0; i < 300 && hit == 0; i++) begin
      @(posedge clk);
      #1 start = (i < 5);
      @(negedge clk);
      if (mem_we && mem_addr == 7'd57) hit = 1;
    end
    chk("reached_addr57", hit, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({done, err, busy, mem_we, mem_addr}), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", int'({done, err, busy, mem_we, mem_addr}), 0);
    quiet();
    run_seq(LAT + 5, 3, LAT + 5);
    count_writes(LAT + 5, nw, ob, wb);
    chk("restart_first_we", t_we[1], 1);
    chk("restart_first_addr", t_addr[1], 0);
    chk("restart_write_count", nw, 100);
    chk("restart_done", t_done[LAT], 1);

`ifdef BOARD_CLEAR_VERIFY_EN
    stuck = 1'b1;
    quiet();
    run_seq(LAT + 5, 3, LAT + 5);
    chk("stuck_err", t_err[LAT], 1);
    chk("stuck_done", t_done[LAT], 1);
    chk("stuck_done_not_early", t_done[LAT - 1], 0);
    stuck = 1'b0;
    quiet();
    run_seq(LAT + 5, 3, LAT + 5);
    chk("clean_again_err", t_err[LAT], 0);
    chk("clean_again_done", t_done[LAT], 1);
`endif

    // Small board, FILL = 3.
    nw2 = 0;
    ob2 = 0;
    wb2 = 0;
    for (int i = 0; i < LAT2 + 8; i++) begin
      @(posedge clk);
      #1 start2 = (i < 3);
      @(negedge clk);
      if (we2) begin
        if (int'(addr2) != nw2) ob2++;
        if (wdata2 != 2'b11) wb2++;
        nw2++;
      end
      if (i == LAT2 - 1) chk("small_done_not_early", int'(done2), 0);
      if (i == LAT2) chk("small_done", int'(done2), 1);
    end
    chk("small_write_count", nw2, 12);
    chk("small_order", ob2, 0);
    chk("small_wdata", wb2, 0);
    nz = 0;
    for (int i = 0; i < 12; i++) if (ram2[i] != 2'b11) nz++;
    chk("small_ram_filled", nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
